mcore8_param: RTL and testbench
===============================

# mcore8_param

Parametrised multi-cycle accumulator-style core, the next generation of the 8-bit four-register processor. It has the same 8-bit instruction set, with configurable data and address widths. A single shared instruction/data memory port uses a req/ack handshake, so memory can have any latency. Adds start/halt control, illegal-opcode detection and a retired-instruction counter for bench and FPGA bring-up.

## Interface
- DATA_W, 8: register/ALU/data width (>= 8).
- ADDR_W, 8: memory address width (<= DATA_W).
- RESET_PC, 0: PC value on reset and on restart.
- COUNT_W, 16: retired-instruction counter width.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE or HALT.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  1 = write (STORE), 0 = read.
- mem_addr  out  ADDR_W  fetch: PC; LOAD/STORE: Rs[ADDR_W-1:0].
- mem_wdata  out  DATA_W  STORE data (Rd).
- mem_rdata  in  DATA_W  read data; fetch uses [7:0].
- mem_ack  in  1  completes the transfer in any cycle mem_req=1 (may be combinational).
- busy  out  1  1 in FETCH/DECODE/EXEC/WB.
- halted  out  1  1 in HALT.
- illegal  out  1  HALT was entered via opcode 6.
- pc  out  ADDR_W  current PC.
- retired  out  COUNT_W  instructions completed, wraps.

## Operation
- Registers R0..R3 (A..D), DATA_W each. Fields: rt=I[5:4], rd=I[3:2], rs=I[1:0], imm=I[3:0].
- 0x0_ ADD: Rd <= Rd+Rs, modulo 2^DATA_W, no flags.
- 0x1_ SUB: Rd <= Rd-Rs, modulo.
- 0x2_ LOAD: Rd <= mem[Rs].
- 0x3_ STORE: mem[Rs] <= Rd.
- 0x4_ JLEZ: if Rs is signed <= 0 (zero or MSB set), PC <= Rd[ADDR_W-1:0]; else PC+1.
- 0x5_ JALR: Rs <= PC+1 (zero-extended), PC <= old Rd. When rd==rs, PC takes the old Rd value.
- 10tt iiii LUI: Rt[7:4] <= imm. Other bits hold.
- 11tt iiii LLI: Rt[3:0] <= imm. Other bits hold.
- 0x6_: illegal. Enter HALT with illegal=1; no register or PC change.
- 0x7_: HALT; PC is left pointing past the HALT byte.
- PC increments modulo 2^ADDR_W; 0xFF+1 wraps to 0 at ADDR_W=8.
- States:
  - IDLE: start -> FETCH.
  - FETCH: req read at PC. On ack, latch instruction, PC <= PC+1 -> DECODE.
  - DECODE: latch Rd/Rs/Rt operands -> EXEC.
  - EXEC:
    - ALU/LUI/LLI/JALR -> WB.
    - LOAD/STORE hold req until ack; LOAD -> WB, STORE -> FETCH.
    - JLEZ updates PC -> FETCH.
    - 0x7_/0x6_ -> HALT.
  - WB: register write -> FETCH.
  - HALT: start clears illegal, PC <= RESET_PC -> FETCH. Registers are kept.
- retired increments on entry to FETCH from EXEC/WB, and on entry to HALT via 0x7_. It does not increment for 0x6_.

## Timing
- Reset values: all registers 0, PC=RESET_PC, state IDLE, mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, busy=0, halted=0, illegal=0, retired=0.
- Zero-wait memory (ack in the same cycle as req):
  - ADD/SUB/LUI/LLI/JALR/LOAD: 4 cycles each.
  - STORE/JLEZ: 3 cycles each.
  - Each memory wait cycle adds 1.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1 and not yet acked. mem_req drops in the cycle after ack unless the next state requests again.
- mem_ack while mem_req=0 is ignored.
- start is ignored while busy=1.
- rst_n=0 mid-transaction: mem_req=0 from the next edge. A pending ack is ignored and no write is retried.
- start and rst_n=0 together: reset wins.

## Test plan
- Reset; preload regs with LLI/LUI program bf f0 (LUI D,F; LLI D,0) -> D=0xF0, retired=2 at HALT byte 0x70, halted=1.
- ADD wrap: A=0xFF, B=0x02, instr 0x01 -> A=0x01. SUB 0x19 with C=2, B=2 -> C=0x00.
- STORE/LOAD with 3-cycle ack delay: B=6, D=0xFF, instr 0x37 -> mem[0xFF]=6. Then 0x2E (LOAD D<=mem[C]), C=0xFF -> D=6. mem_addr/mem_wdata stay stable across the wait.
- JLEZ loop: A=0xFE, C=1, prog 02 44 70 -> loops until A=0x01, then halts. JALR 0x5F with D=6 -> PC=6, D=1.
- Opcode 0x65 -> halted=1, illegal=1, registers unchanged, retired unchanged. Then pulse start -> illegal=0, PC=RESET_PC.
- Assert rst_n=0 while a LOAD is awaiting ack -> next cycle mem_req=0, all outputs at reset values. A late ack causes no register change.

Source files
------------

// File: rtl/mcore8_param.sv
// ============================================================================
// mcore8_param : parametrised multi-cycle four-register accumulator core
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mcore8_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0,
   parameter int COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ack,
   output logic               busy,
   output logic               halted,
   output logic               illegal,
   output logic [ADDR_W-1:0]  pc,
   output logic [COUNT_W-1:0] retired
);

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [7:0]           ir_q, ir_d;
   logic [DATA_W-1:0]    regs_q [4];
   logic [DATA_W-1:0]    rdv_q, rdv_d;
   logic [DATA_W-1:0]    rsv_q, rsv_d;
   logic [DATA_W-1:0]    rtv_q, rtv_d;
   logic [DATA_W-1:0]    res_q, res_d;
   logic                 illegal_q, illegal_d;
   logic [COUNT_W-1:0]   retired_q, retired_d;
   logic                 reg_we;
   logic [1:0]           reg_wsel;

   // Write-back target: LUI/LLI use rt, JALR links into rs, everything else rd
   always_comb begin
      reg_wsel = ir_q[3:2];
      if (ir_q[7])
         reg_wsel = ir_q[5:4];
      else if (ir_q[6:4] == 3'd5)
         reg_wsel = ir_q[1:0];
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      rdv_d     = rdv_q;
      rsv_d     = rsv_q;
      rtv_d     = rtv_q;
      res_d     = res_q;
      illegal_d = illegal_q;
      retired_d = retired_q;
      reg_we    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = rdv_q;

      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_d    = mem_rdata[7:0];
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            rdv_d   = regs_q[ir_q[3:2]];
            rsv_d   = regs_q[ir_q[1:0]];
            rtv_d   = regs_q[ir_q[5:4]];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (ir_q[7]) begin
               res_d = rtv_q;
               if (ir_q[6])
                  res_d[3:0] = ir_q[3:0];
               else
                  res_d[7:4] = ir_q[3:0];
               state_d = S_WB;
            end else begin
               case (ir_q[6:4])
                  3'd0: begin
                     res_d   = rdv_q + rsv_q;
                     state_d = S_WB;
                  end
                  3'd1: begin
                     res_d   = rdv_q - rsv_q;
                     state_d = S_WB;
                  end
                  3'd2: begin
                     mem_req  = 1'b1;
                     mem_addr = rsv_q[ADDR_W-1:0];
                     if (mem_ack) begin
                        res_d   = mem_rdata;
                        state_d = S_WB;
                     end
                  end
                  3'd3: begin
                     mem_req  = 1'b1;
                     mem_we   = 1'b1;
                     mem_addr = rsv_q[ADDR_W-1:0];
                     if (mem_ack) begin
                        retired_d = retired_q + COUNT_W'(1);
                        state_d   = S_FETCH;
                     end
                  end
                  3'd4: begin
                     if (rsv_q[DATA_W-1] || (rsv_q == '0))
                        pc_d = rdv_q[ADDR_W-1:0];
                     retired_d = retired_q + COUNT_W'(1);
                     state_d   = S_FETCH;
                  end
                  3'd5: begin
                     // pc_q already holds the return address after fetch
                     res_d   = DATA_W'(pc_q);
                     pc_d    = rdv_q[ADDR_W-1:0];
                     state_d = S_WB;
                  end
                  3'd6: begin
                     illegal_d = 1'b1;
                     state_d   = S_HALT;
                  end
                  default: begin
                     retired_d = retired_q + COUNT_W'(1);
                     state_d   = S_HALT;
                  end
               endcase
            end
         end
         S_WB: begin
            reg_we    = 1'b1;
            retired_d = retired_q + COUNT_W'(1);
            state_d   = S_FETCH;
         end
         S_HALT: begin
            if (start) begin
               illegal_d = 1'b0;
               pc_d      = PC_RST;
               state_d   = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= PC_RST;
         ir_q      <= '0;
         rdv_q     <= '0;
         rsv_q     <= '0;
         rtv_q     <= '0;
         res_q     <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
         for (int i = 0; i < 4; i++)
            regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         rdv_q     <= rdv_d;
         rsv_q     <= rsv_d;
         rtv_q     <= rtv_d;
         res_q     <= res_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
         if (reg_we)
            regs_q[reg_wsel] <= res_q;
      end
   end

   assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC)  || (state_q == S_WB);
   assign halted  = (state_q == S_HALT);
   assign illegal = illegal_q;
   assign pc      = pc_q;
   assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mcore8_param.sv
// ============================================================================
// tb_mcore8_param : directed self-checking bench for mcore8_param
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mcore8_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mem_req, mem_we, mem_ack;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata, pc;
   logic        busy, halted, illegal;
   logic [15:0] retired;

   logic [7:0]  mem [256];
   int          ack_delay = 0;
   logic        ack_en    = 1'b1;
   logic        ack_force = 1'b0;
   int          wcnt      = 0;
   logic        ld_en     = 1'b0;
   logic [7:0]  ld_addr   = '0;
   logic [7:0]  ld_data   = '0;
   logic [7:0]  prog_q [$];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cycles  = 0;
   int          stab_err = 0;
   logic        pend = 1'b0;
   logic [7:0]  sv_addr = '0, sv_wdata = '0;
   logic        sv_we = 1'b0;

   always #5 clk = ~clk;

   mcore8_param #(
      .DATA_W(8), .ADDR_W(8), .RESET_PC(0), .COUNT_W(16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .halted    (halted),
      .illegal   (illegal),
      .pc        (pc),
      .retired   (retired)
   );

   // Memory model: ack after ack_delay wait cycles, combinational when zero
   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = ack_force || (mem_req && ack_en && (wcnt >= ack_delay));

   always @(posedge clk) begin
      if (ld_en)
         mem[ld_addr] <= ld_data;
      else if (mem_req && mem_ack && mem_we)
         mem[mem_addr] <= mem_wdata;
      if (mem_req && !mem_ack)
         wcnt <= wcnt + 1;
      else
         wcnt <= 0;
   end

   // Address/data/direction must hold while a request waits for its ack
   always @(negedge clk) begin
      if (pend && mem_req &&
          (mem_addr !== sv_addr || mem_wdata !== sv_wdata || mem_we !== sv_we))
         stab_err <= stab_err + 1;
      pend     <= mem_req && !mem_ack;
      sv_addr  <= mem_addr;
      sv_wdata <= mem_wdata;
      sv_we    <= mem_we;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      ack_force = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic load_prog(input logic [7:0] base);
      for (int i = 0; i < prog_q.size(); i++) begin
         ld_en   = 1'b1;
         ld_addr = base + 8'(i);
         ld_data = prog_q[i];
         @(posedge clk); #1;
      end
      ld_en = 1'b0;
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_halt();
      cycles = 0;
      while (!halted && cycles < 2000) begin
         @(posedge clk); #1;
         cycles++;
      end
      n_tests++;
      if (!halted) begin
         n_fail++;
         $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, cycles);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({mem_req, mem_we, busy, halted, illegal} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: req/we/busy/halted/illegal=%b required 00000",
                  {mem_req, mem_we, busy, halted, illegal});
      end
      n_tests++;
      if (mem_addr !== 8'h00 || mem_wdata !== 8'h00 || pc !== 8'h00 || retired !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_values: addr=%h wdata=%h pc=%h retired=%0d required 00 00 00 0",
                  mem_addr, mem_wdata, pc, retired);
      end
   endtask

   task automatic test_preload();
      do_reset();
      ack_delay = 0;
      prog_q = '{8'hBF, 8'hF0, 8'hC8, 8'h3C, 8'h70};
      load_prog(8'h00);
      poke(8'h08, 8'h00);
      pulse_start();
      wait_halt();
      n_tests++;
      if (mem[8'h08] !== 8'hF0) begin
         n_fail++;
         $display("FAIL preload_D: stored %h required f0", mem[8'h08]);
      end
      n_tests++;
      if (retired !== 16'd5 || pc !== 8'h05 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL preload_state: retired=%0d pc=%h illegal=%0b required 5 05 0",
                  retired, pc, illegal);
      end
      n_tests++;
      if (cycles !== 18) begin
         n_fail++;
         $display("FAIL preload_cycles: %0d required 18", cycles);
      end
   endtask

   task automatic test_alu();
      do_reset();
      ack_delay = 0;
      prog_q = '{8'h8F, 8'hCF, 8'h90, 8'hD2, 8'hA0, 8'hE2, 8'hB4, 8'hF0,
                 8'h01, 8'h19, 8'h33, 8'hF1, 8'h3B, 8'h70};
      load_prog(8'h00);
      poke(8'h40, 8'hAA);
      poke(8'h41, 8'hAA);
      pulse_start();
      wait_halt();
      n_tests++;
      if (mem[8'h40] !== 8'h01) begin
         n_fail++;
         $display("FAIL add_wrap: A=%h required 01", mem[8'h40]);
      end
      n_tests++;
      if (mem[8'h41] !== 8'h00) begin
         n_fail++;
         $display("FAIL sub_zero: C=%h required 00", mem[8'h41]);
      end
      n_tests++;
      if (cycles !== 53 || retired !== 16'd14) begin
         n_fail++;
         $display("FAIL alu_timing: cycles=%0d retired=%0d required 53 14", cycles, retired);
      end
   endtask

   task automatic test_store_load();
      int s0;
      do_reset();
      ack_delay = 3;
      prog_q = '{8'h90, 8'hD6, 8'hBF, 8'hFF, 8'h37, 8'hAF, 8'hEF, 8'h2E,
                 8'h85, 8'hC0, 8'h3C, 8'h70};
      load_prog(8'h00);
      poke(8'hFF, 8'h00);
      poke(8'h50, 8'h00);
      s0 = stab_err;
      pulse_start();
      wait_halt();
      n_tests++;
      if (mem[8'hFF] !== 8'h06) begin
         n_fail++;
         $display("FAIL store_wait: mem[ff]=%h required 06", mem[8'hFF]);
      end
      n_tests++;
      if (mem[8'h50] !== 8'h06) begin
         n_fail++;
         $display("FAIL load_wait: D=%h required 06", mem[8'h50]);
      end
      n_tests++;
      if (cycles !== 90) begin
         n_fail++;
         $display("FAIL wait_cycles: %0d required 90", cycles);
      end
      n_tests++;
      if (stab_err !== s0) begin
         n_fail++;
         $display("FAIL req_stable: %0d unstable wait cycles, required 0", stab_err - s0);
      end
      ack_delay = 0;
   endtask

   task automatic test_jump();
      do_reset();
      ack_delay = 0;
      prog_q = '{8'h8F, 8'hCE, 8'hA0, 8'hE1, 8'h90, 8'hD8, 8'hB6, 8'hF0,
                 8'h02, 8'h44, 8'h33, 8'h70};
      load_prog(8'h00);
      poke(8'h60, 8'hEE);
      pulse_start();
      wait_halt();
      n_tests++;
      if (mem[8'h60] !== 8'h01) begin
         n_fail++;
         $display("FAIL jlez_loop: A=%h required 01", mem[8'h60]);
      end
      n_tests++;
      if (retired !== 16'd16 || pc !== 8'h0C || cycles !== 59) begin
         n_fail++;
         $display("FAIL jlez_state: retired=%0d pc=%h cycles=%0d required 16 0c 59",
                  retired, pc, cycles);
      end
      // D=6 held across restart, then JALR D,D from address 0
      prog_q = '{8'hB0, 8'hF6, 8'h70};
      load_prog(8'h00);
      pulse_start();
      wait_halt();
      prog_q = '{8'h5F};
      load_prog(8'h00);
      prog_q = '{8'h87, 8'hC0, 8'h3C, 8'h70};
      load_prog(8'h06);
      poke(8'h70, 8'hEE);
      pulse_start();
      wait_halt();
      n_tests++;
      if (mem[8'h70] !== 8'h01) begin
         n_fail++;
         $display("FAIL jalr_link: D=%h required 01", mem[8'h70]);
      end
      n_tests++;
      if (pc !== 8'h0A || cycles !== 18) begin
         n_fail++;
         $display("FAIL jalr_target: pc=%h cycles=%0d required 0a 18", pc, cycles);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      ack_delay = 0;
      prog_q = '{8'hC5, 8'h65};
      load_prog(8'h00);
      pulse_start();
      wait_halt();
      n_tests++;
      if (halted !== 1'b1 || illegal !== 1'b1 || retired !== 16'd1 || cycles !== 7) begin
         n_fail++;
         $display("FAIL illegal_halt: halted=%0b illegal=%0b retired=%0d cycles=%0d required 1 1 1 7",
                  halted, illegal, retired, cycles);
      end
      prog_q = '{8'h98, 8'h31, 8'h70};
      load_prog(8'h00);
      poke(8'h80, 8'hEE);
      pulse_start();
      n_tests++;
      if (illegal !== 1'b0 || pc !== 8'h00 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart: illegal=%0b pc=%h busy=%0b required 0 00 1", illegal, pc, busy);
      end
      wait_halt();
      n_tests++;
      if (mem[8'h80] !== 8'h05 || retired !== 16'd4 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_regs: A=%h retired=%0d illegal=%0b required 05 4 0",
                  mem[8'h80], retired, illegal);
      end
   endtask

   task automatic test_reset_mid_load();
      int guard;
      do_reset();
      ack_delay = 10;
      prog_q = '{8'hA9, 8'h2E};
      load_prog(8'h00);
      poke(8'h90, 8'h5A);
      pulse_start();
      guard = 0;
      while (!(mem_req && mem_addr == 8'h90) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      n_tests++;
      if (!(mem_req && mem_addr == 8'h90)) begin
         n_fail++;
         $display("FAIL load_pending: req=%0b addr=%h required 1 90", mem_req, mem_addr);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({mem_req, mem_we, busy, halted, illegal} !== 5'b0 || mem_addr !== 8'h00 ||
          mem_wdata !== 8'h00 || pc !== 8'h00 || retired !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_load: flags=%b addr=%h wdata=%h pc=%h retired=%0d required 00000 00 00 00 0",
                  {mem_req, mem_we, busy, halted, illegal}, mem_addr, mem_wdata, pc, retired);
      end
      ack_force = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL late_ack: busy=%0b req=%0b required 0 0", busy, mem_req);
      end
      ack_force = 1'b0;
      ack_delay = 0;
      prog_q = '{8'h8A, 8'h3C, 8'h70};
      load_prog(8'h00);
      poke(8'hA0, 8'h77);
      pulse_start();
      wait_halt();
      n_tests++;
      if (mem[8'hA0] !== 8'h00) begin
         n_fail++;
         $display("FAIL late_ack_regs: D=%h required 00", mem[8'hA0]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      test_reset();
      test_preload();
      test_alu();
      test_store_load();
      test_jump();
      test_illegal();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
